// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// State encodings and mode bit values are fixed so that other blocks can decode them.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder.
// It is the only arithmetic cell in the serial datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, with a start/busy/done handshake.
// Subtraction is computed as a + ~b + 1 by preloading ~b and a carry of 1.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_nxt;
  logic             last_bit;

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (sum_bit),
    .cout (carry_nxt)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_next = {sum_bit, res_sh[WIDTH-1:1]};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
    end
  end

  // Output registers load only on the final bit, so they hold through later RUNs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= (sub == MODE_SUB) ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            result <= res_next;
            c_out  <= carry_nxt;
            ovf    <= carry ^ carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
